// File: rtl/prefix_adder_arbiter_if.sv
// Request/response bundle for the shared prefix-adder arbiter.
// master = requesters plus response consumer, slave = the arbiter.
interface prefix_adder_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 16,
    parameter int IDW   = $clog2(NREQ)
) ();
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ-1:0]       req_cin;
    logic [NREQ-1:0]       req_last;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH-1:0]      rsp_sum;
    logic                  rsp_cout;
    logic                  rsp_last;

    modport master (
        output req_valid, req_a, req_b, req_cin, req_last, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_last
    );

    modport slave (
        input  req_valid, req_a, req_b, req_cin, req_last, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_last
    );
endinterface

// File: rtl/prefix_adder_arbiter.sv
// One WIDTH-bit parallel-prefix adder shared by NREQ requesters.
// Round-robin per burst; burst beats chain their carry LSW first;
// one registered response slot with backpressure.
module prefix_adder_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 16,
    parameter int IDW   = $clog2(NREQ)
) (
    input logic                  clk,
    input logic                  rst_n,
    prefix_adder_arbiter_if.slave bus
);
    localparam int LVLS = $clog2(WIDTH);

    typedef enum logic {IDLE, BURST} state_e;

    state_e           state_q, state_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]   owner_q, owner_d;
    logic             carry_q, carry_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]   rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] rsp_sum_q, rsp_sum_d;
    logic             rsp_cout_q, rsp_cout_d;
    logic             rsp_last_q, rsp_last_d;

    logic [IDW-1:0]   win, sel, idx;
    logic             win_vld, grant_vld, slot_free, accept;
    logic [NREQ-1:0]  ready;
    logic [WIDTH-1:0] op_a, op_b, sum;
    logic             cin_sel, last_sel, cout;

    function automatic logic [IDW-1:0] inc_wrap(input logic [IDW-1:0] v);
        return (v == IDW'(NREQ-1)) ? '0 : v + 1'b1;
    endfunction

    // Round-robin winner: first valid requester at or after rr_ptr.
    // Scanning downward lets the lowest offset overwrite the others.
    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        idx     = '0;
        for (int k = NREQ-1; k >= 0; k--) begin
            idx = IDW'((int'(rr_ptr_q) + k) % NREQ);
            if (bus.req_valid[idx]) begin
                win     = idx;
                win_vld = 1'b1;
            end
        end
    end

    // Grant and operand selection; a burst owner keeps the grant even while idle.
    always_comb begin
        sel       = (state_q == BURST) ? owner_q : win;
        grant_vld = (state_q == BURST) || win_vld;
        slot_free = !rsp_valid_q || bus.rsp_ready;
        ready     = (grant_vld && slot_free) ? (NREQ'(1) << sel) : '0;
        accept    = |(ready & bus.req_valid);
        op_a      = bus.req_a[sel*WIDTH +: WIDTH];
        op_b      = bus.req_b[sel*WIDTH +: WIDTH];
        cin_sel   = (state_q == BURST) ? carry_q : bus.req_cin[sel];
        last_sel  = bus.req_last[sel];
    end

    // Knowles [1,1,...,1] prefix network; carry-in folded into bit 0 generate.
    logic [LVLS:0][WIDTH-1:0]   gl;
    logic [LVLS-1:0][WIDTH-1:0] pl;
    logic [WIDTH-1:0]           pxor;
    logic [WIDTH:0]             carry;

    assign pxor  = op_a ^ op_b;
    assign gl[0] = (op_a & op_b) | {{(WIDTH-1){1'b0}}, pxor[0] & cin_sel};
    assign pl[0] = pxor;

    for (genvar l = 0; l < LVLS; l++) begin : g_lvl
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            if (i >= (1 << l)) begin : g_op
                assign gl[l+1][i] = gl[l][i] | (pl[l][i] & gl[l][i-(1<<l)]);
                if (l < LVLS-1) begin : g_p
                    assign pl[l+1][i] = pl[l][i] & pl[l][i-(1<<l)];
                end
            end else begin : g_pass
                assign gl[l+1][i] = gl[l][i];
                if (l < LVLS-1) begin : g_p
                    assign pl[l+1][i] = pl[l][i];
                end
            end
        end
    end

    assign carry = {gl[LVLS], cin_sel};
    assign sum   = pxor ^ carry[WIDTH-1:0];
    assign cout  = carry[WIDTH];

    // Next-state: arbitration FSM, carry chain and response slot.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        carry_d     = carry_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_cout_d  = rsp_cout_q;
        rsp_last_d  = rsp_last_q;
        if (accept) begin
            rsp_valid_d = 1'b1;
            rsp_id_d    = sel;
            rsp_sum_d   = sum;
            rsp_cout_d  = cout;
            rsp_last_d  = last_sel;
            carry_d     = cout;
            if (state_q == IDLE) begin
                if (last_sel) begin
                    rr_ptr_d = inc_wrap(sel);
                end else begin
                    state_d = BURST;
                    owner_d = sel;
                end
            end else if (last_sel) begin
                state_d  = IDLE;
                rr_ptr_d = inc_wrap(owner_q);
            end
        end else if (bus.rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    // State and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            carry_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_sum_q   <= '0;
            rsp_cout_q  <= 1'b0;
            rsp_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            carry_q     <= carry_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_cout_q  <= rsp_cout_d;
            rsp_last_q  <= rsp_last_d;
        end
    end

    assign bus.req_ready = ready;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_sum   = rsp_sum_q;
    assign bus.rsp_cout  = rsp_cout_q;
    assign bus.rsp_last  = rsp_last_q;
endmodule

// File: tb/tb_prefix_adder_arbiter.sv
// Bench for prefix_adder_arbiter: per-requester beat queues, a wide-add
// scoreboard per requester id, and directed scenarios plus a random run.
module tb_prefix_adder_arbiter;
    localparam int NREQ  = 4;
    localparam int WIDTH = 16;
    localparam int IDW   = $clog2(NREQ);
    localparam int MAXB  = 4;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             cin;
        logic             last;
    } beat_t;

    typedef struct packed {
        logic [IDW-1:0]   id;
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             last;
    } rsp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    prefix_adder_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();
    prefix_adder_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int    checks = 0;
    int    errors = 0;
    beat_t drv_q[NREQ][$];
    rsp_t  exp_q[NREQ][$];
    int    acc_log[$];
    rsp_t  rsp_log[$];
    int    hold[NREQ];
    int    force_gap[NREQ];
    int    gap_pct = 0;
    bit    rand_rdy = 0;
    int    stall = 0;
    int    open_id = -1;
    int    rsp_open = -1;
    bit    prev_stall = 0;
    rsp_t  prev_rsp;
    int    hs_cnt = 0;

    function automatic rsp_t cur_rsp();
        rsp_t r;
        r.id = bus.rsp_id; r.sum = bus.rsp_sum; r.cout = bus.rsp_cout; r.last = bus.rsp_last;
        return r;
    endfunction

    function automatic bit busy();
        for (int i = 0; i < NREQ; i++)
            if (drv_q[i].size() != 0 || exp_q[i].size() != 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < NREQ; i++) begin
            drv_q[i].delete(); exp_q[i].delete();
            hold[i] = 0; force_gap[i] = -1;
        end
        open_id = -1; rsp_open = -1; prev_stall = 0;
    endtask

    // Queue a burst of nb beats; expected chunks come from one wide addition.
    task automatic add_burst(input int r, input int nb, input logic [MAXB*WIDTH-1:0] A,
                             input logic [MAXB*WIDTH-1:0] B, input logic cin);
        logic [MAXB*WIDTH:0] part, m;
        beat_t bt;
        rsp_t  rs;
        for (int k = 0; k < nb; k++) begin
            bt.a = A[k*WIDTH +: WIDTH]; bt.b = B[k*WIDTH +: WIDTH];
            bt.cin = (k == 0) ? cin : ~cin;
            bt.last = (k == nb-1);
            drv_q[r].push_back(bt);
            m = '1;
            m = m >> (MAXB*WIDTH + 1 - (k+1)*WIDTH);
            part = ({1'b0, A} & m) + ({1'b0, B} & m) + {{(MAXB*WIDTH){1'b0}}, cin};
            rs.id = IDW'(r); rs.sum = part[k*WIDTH +: WIDTH];
            rs.cout = part[(k+1)*WIDTH]; rs.last = bt.last;
            exp_q[r].push_back(rs);
        end
    endtask

    // One clock: drive at negedge, check and log handshakes just before posedge.
    task automatic step();
        logic [NREQ-1:0]       v, c, l;
        logic [NREQ*WIDTH-1:0] a, b;
        rsp_t  cur;
        beat_t bt;
        @(negedge clk);
        for (int i = 0; i < NREQ; i++) begin
            if (drv_q[i].size() > 0 && hold[i] == 0) begin
                v[i] = 1'b1; a[i*WIDTH +: WIDTH] = drv_q[i][0].a; b[i*WIDTH +: WIDTH] = drv_q[i][0].b;
                c[i] = drv_q[i][0].cin; l[i] = drv_q[i][0].last;
            end else begin
                v[i] = 1'b0; a[i*WIDTH +: WIDTH] = WIDTH'($urandom); b[i*WIDTH +: WIDTH] = WIDTH'($urandom);
                c[i] = 1'($urandom); l[i] = 1'($urandom);
                if (hold[i] > 0) hold[i]--;
            end
        end
        bus.req_valid = v; bus.req_a = a; bus.req_b = b; bus.req_cin = c; bus.req_last = l;
        if (stall > 0) begin bus.rsp_ready = 1'b0; stall--; end
        else bus.rsp_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
        #1;
        cur = cur_rsp();
        checks++;
        if ($countones(bus.req_ready) > 1) begin errors++; $display("FAIL onehot: req_ready=%b", bus.req_ready); end
        if (open_id >= 0) begin
            checks++;
            if ((bus.req_ready & ~(NREQ'(1) << open_id)) !== '0) begin
                errors++; $display("FAIL burst_lock: owner=%0d req_ready=%b", open_id, bus.req_ready);
            end
        end
        if (bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b0) begin
            checks++;
            if (bus.req_ready !== '0) begin errors++; $display("FAIL slot_full_ready: req_ready=%b want 0", bus.req_ready); end
        end
        if (prev_stall) begin
            checks++;
            if (bus.rsp_valid !== 1'b1 || cur !== prev_rsp) begin
                errors++; $display("FAIL rsp_hold: got v=%b %h want v=1 %h", bus.rsp_valid, cur, prev_rsp);
            end
        end
        if (bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) begin
            hs_cnt++; rsp_log.push_back(cur);
            if (rsp_open >= 0) begin
                checks++;
                if (int'(cur.id) != rsp_open) begin errors++; $display("FAIL interleave: id=%0d want %0d", cur.id, rsp_open); end
            end
            checks++;
            if (exp_q[cur.id].size() == 0) begin
                errors++; $display("FAIL unexpected_rsp: id=%0d sum=%h with nothing pending", cur.id, cur.sum);
            end else begin
                if (cur !== exp_q[cur.id][0]) begin
                    errors++; $display("FAIL rsp_data: got id=%0d sum=%h c=%b l=%b want sum=%h c=%b l=%b", cur.id,
                                       cur.sum, cur.cout, cur.last, exp_q[cur.id][0].sum, exp_q[cur.id][0].cout, exp_q[cur.id][0].last);
                end
                void'(exp_q[cur.id].pop_front());
            end
            rsp_open = cur.last ? -1 : int'(cur.id);
        end
        for (int i = 0; i < NREQ; i++) begin
            if (bus.req_valid[i] && bus.req_ready[i]) begin
                acc_log.push_back(i);
                bt = drv_q[i].pop_front();
                open_id = bt.last ? -1 : i;
                if (force_gap[i] >= 0) begin hold[i] = force_gap[i]; force_gap[i] = -1; end
                else if ($urandom_range(0, 99) < gap_pct) hold[i] = $urandom_range(1, 3);
            end
        end
        prev_stall = (bus.rsp_valid === 1'b1) && (bus.rsp_ready === 1'b0);
        prev_rsp = cur;
    endtask

    task automatic drain(input int limit);
        int n = 0;
        while (busy() && n < limit) begin step(); n++; end
        checks++;
        if (busy()) begin errors++; $display("FAIL drain_timeout: still busy after %0d cycles", limit); end
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.req_valid = '0; bus.rsp_ready = 1'b0; rst_n = 1'b0;
        clear_model();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        bus.req_valid = '0; bus.req_a = '0; bus.req_b = '0; bus.req_cin = '0; bus.req_last = '0;
        bus.rsp_ready = 1'b1;
        clear_model();
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks += 6;
        if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.rsp_valid); end
        if (bus.rsp_id !== '0) begin errors++; $display("FAIL reset_id: got %0d want 0", bus.rsp_id); end
        if (bus.rsp_sum !== '0) begin errors++; $display("FAIL reset_sum: got %h want 0", bus.rsp_sum); end
        if (bus.rsp_cout !== 1'b0) begin errors++; $display("FAIL reset_cout: got %b want 0", bus.rsp_cout); end
        if (bus.rsp_last !== 1'b0) begin errors++; $display("FAIL reset_last: got %b want 0", bus.rsp_last); end
        if (bus.req_ready !== '0) begin errors++; $display("FAIL reset_ready: got %b want 0", bus.req_ready); end
        rst_n = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.req_ready !== '0) begin
            errors++; $display("FAIL post_reset_idle: v=%b ready=%b want 0/0", bus.rsp_valid, bus.req_ready);
        end
    endtask

    task automatic test_single();
        int b = acc_log.size();
        add_burst(0, 1, 64'hFFFF, 64'h0001, 1'b0);
        step();
        checks += 2;
        if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL t1_ready: got %b want 0001", bus.req_ready); end
        if (acc_log.size() != b+1) begin errors++; $display("FAIL t1_accept: got %0d accepts want 1", acc_log.size()-b); end
        @(posedge clk); #1;
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_sum !== 16'h0000 || bus.rsp_cout !== 1'b1 ||
            bus.rsp_id !== 2'd0 || bus.rsp_last !== 1'b1) begin
            errors++; $display("FAIL t1_rsp: got v=%b sum=%h c=%b id=%0d l=%b want 1 0000 1 0 1",
                               bus.rsp_valid, bus.rsp_sum, bus.rsp_cout, bus.rsp_id, bus.rsp_last);
        end
        drain(20);
    endtask

    task automatic test_burst();
        int   b = rsp_log.size();
        rsp_t e0, e1;
        e0 = '{id: IDW'(2), sum: 16'h0001, cout: 1'b1, last: 1'b0};
        e1 = '{id: IDW'(2), sum: 16'h0002, cout: 1'b0, last: 1'b1};
        add_burst(2, 2, 64'h0001_FFFF, 64'h0000_0001, 1'b1);
        drain(20);
        checks++;
        if (rsp_log.size() != b+2) begin
            errors++; $display("FAIL t2_count: got %0d rsps want 2", rsp_log.size()-b);
        end else begin
            checks++;
            if (rsp_log[b] !== e0 || rsp_log[b+1] !== e1) begin
                errors++; $display("FAIL t2_rsp: got %h %h want %h %h", rsp_log[b], rsp_log[b+1], e0, e1);
            end
        end
    endtask

    task automatic test_fairness();
        int b, h;
        do_reset();
        for (int j = 0; j < 3; j++)
            for (int r = 0; r < NREQ; r++)
                add_burst(r, 1, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom));
        b = acc_log.size(); h = hs_cnt;
        repeat (12) step();
        checks += 2;
        if (acc_log.size() != b+12) begin
            errors++; $display("FAIL t3_rate: got %0d accepts in 12 cycles want 12", acc_log.size()-b);
        end else begin
            for (int k = 0; k < 12; k++) begin
                checks++;
                if (acc_log[b+k] != k % NREQ) begin errors++; $display("FAIL t3_order[%0d]: got %0d want %0d", k, acc_log[b+k], k % NREQ); end
            end
        end
        if (hs_cnt - h != 11) begin errors++; $display("FAIL t3_rsp_rate: got %0d rsps want 11", hs_cnt-h); end
        drain(20);
    endtask

    task automatic test_burst_lock();
        int b, want[4];
        want = '{1, 1, 1, 3};
        do_reset();
        add_burst(1, 3, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom));
        add_burst(3, 1, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom));
        force_gap[1] = 2;
        b = acc_log.size();
        drain(50);
        checks++;
        if (acc_log.size() != b+4) begin
            errors++; $display("FAIL t4_count: got %0d accepts want 4", acc_log.size()-b);
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (acc_log[b+k] != want[k]) begin errors++; $display("FAIL t4_order[%0d]: got %0d want %0d", k, acc_log[b+k], want[k]); end
            end
        end
    endtask

    task automatic test_backpressure();
        int   b;
        rsp_t snap;
        do_reset();
        add_burst(0, 1, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1);
        add_burst(1, 1, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0);
        add_burst(2, 3, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1);
        b = rsp_log.size();
        step();
        stall = 4;
        for (int k = 0; k < 4; k++) begin
            step();
            if (k == 0) snap = cur_rsp();
            checks++;
            if (bus.rsp_valid !== 1'b1 || bus.req_ready !== '0 || cur_rsp() !== snap) begin
                errors++; $display("FAIL t5_stall[%0d]: v=%b ready=%b rsp=%h want 1 0 %h", k,
                                   bus.rsp_valid, bus.req_ready, cur_rsp(), snap);
            end
        end
        drain(40);
        checks++;
        if (rsp_log.size() - b != 5) begin errors++; $display("FAIL t5_drain: got %0d rsps want 5", rsp_log.size()-b); end
    endtask

    task automatic test_reset_mid_burst();
        int   b;
        rsp_t e;
        e = '{id: IDW'(2), sum: 16'h0000, cout: 1'b0, last: 1'b1};
        do_reset();
        add_burst(0, 2, 64'h0000_FFFF, 64'h0000_0001, 1'b0);
        b = acc_log.size();
        step();
        checks++;
        if (acc_log.size() != b+1) begin errors++; $display("FAIL t6_beat1: got %0d accepts want 1", acc_log.size()-b); end
        @(posedge clk); #1;
        bus.req_valid = '0; rst_n = 1'b0;
        #1;
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.rsp_sum !== '0 || bus.req_ready !== '0) begin
            errors++; $display("FAIL t6_reset: v=%b sum=%h ready=%b want 0 0 0", bus.rsp_valid, bus.rsp_sum, bus.req_ready);
        end
        clear_model();
        @(negedge clk); rst_n = 1'b1;
        b = rsp_log.size();
        add_burst(2, 1, 64'h0, 64'h0, 1'b0);
        drain(20);
        checks++;
        if (rsp_log.size() != b+1 || rsp_log[rsp_log.size()-1] !== e) begin
            errors++; $display("FAIL t6_after: got %0d rsps last=%h want 1 %h", rsp_log.size()-b,
                               (rsp_log.size() > 0) ? rsp_log[rsp_log.size()-1] : '0, e);
        end
    endtask

    task automatic test_random();
        logic [MAXB*WIDTH-1:0] A, B;
        do_reset();
        rand_rdy = 1; gap_pct = 30;
        repeat (60) begin
            A = {$urandom, $urandom};
            B = ($urandom_range(0, 3) == 0) ? ~A : {$urandom, $urandom};
            add_burst($urandom_range(0, NREQ-1), $urandom_range(1, MAXB), A, B, 1'($urandom));
        end
        drain(5000);
        rand_rdy = 0; gap_pct = 0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_fairness();
        test_burst_lock();
        test_backpressure();
        test_reset_mid_burst();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
